ctrl_pipe_unit: RTL and testbench
=================================

// Module: ctrl_pipe_unit
// PURPOSE
//  Main-decoder successor for the pipelined RV32 core. Decodes Op_i in ID and carries the
//  control bundle through ID/EX, EX/MEM and MEM/WB registers, so every stage has its own view.
//  Detects load-use hazards, inserts bubbles on hazard or flush, and freezes on external stall.
//  Adds bne/jal/lui decoding (EXT_EN) and an explicit illegal-opcode path.
// PARAMETERS
//  OPW      7  opcode width
//  RIW      5  register-index width
//  EXT_EN   1  1: decode bne(1100011,f3=001)/jal(1101111)/lui(0110111); 0: these are illegal
//  HAZ_EN   1  1: load-use detection active; 0: hazard_o tied 0
// PORTS
//  clk_i          in   1    clock, rising edge
//  rst_i          in   1    synchronous reset, active-high
//  valid_i        in   1    ID holds a real instruction; 0 decodes as bubble
//  Op_i           in   OPW  opcode of ID instruction
//  funct3_i       in   3    funct3 of ID instruction (beq/bne select)
//  rs1_i, rs2_i   in   RIW  source indices of ID instruction
//  rd_i           in   RIW  destination index of ID instruction
//  stall_i        in   1    external freeze (e.g. memory wait): all stage registers hold
//  flush_i        in   1    taken branch/jump: ID/EX loads a bubble
//  hazard_o       out  1    load-use stall request to PC/IF-ID (combinational)
//  illegal_o      out  1    registered: ID/EX holds an illegal opcode
//  ex_ALUOp_o     out  2    00 ld/st/lui, 01 branch, 10 R, 11 I-ALU
//  ex_ALUSrc_o    out  1    1 = immediate operand
//  ex_Branch_o    out  1    beq/bne
//  ex_BrNe_o      out  1    1 = bne
//  ex_Jump_o      out  1    jal
//  mem_MemRead_o  out  1
//  mem_MemWrite_o out  1
//  wb_RegWrite_o  out  1
//  wb_Mem2Reg_o   out  1
// BEHAVIOUR
//  Decode (comb, ID): 0010011 I-ALU {11,Src1,RW1}; 0110011 R {10,Src0,RW1};
//   1100011 f3=000 beq {01,Br1}; f3=001 bne {01,Br1,BrNe1} (EXT_EN); other f3 illegal;
//   0000011 lw {00,Src1,MR1,RW1,M2R1}; 0100011 sw {00,Src1,MW1};
//   1101111 jal {00,Jump1,RW1}; 0110111 lui {00,Src1,RW1}; unlisted fields = 0.
//  Any other opcode: all-zero bundle, illegal flag set. No opcode defaults to load.
//  valid_i=0: bundle forced all-zero, illegal flag 0.
//  Pipeline: bundle of ID cycle n visible on ex_* at n+1, mem_* at n+2, wb_* at n+3.
//   ID/EX carries full bundle + rd + MemRead; EX/MEM drops ex fields; MEM/WB keeps wb fields.
//  Load-use: hazard_o = HAZ_EN & valid_i & idex.MemRead & idex.rd!=0 &
//   (idex.rd==rs1_i | idex.rd==rs2_i). rs2 compared regardless of opcode (conservative).
//  Per-edge priority: rst_i > stall_i > flush_i > hazard_o > normal load.
//   rst_i: every stage register and every output = 0 (incl. illegal_o); hazard_o then 0.
//   stall_i: all three stage registers hold; hazard_o still computed from held ID/EX.
//   flush_i (no stall): ID/EX <- bubble; EX/MEM, MEM/WB advance.
//   hazard_o (no stall/flush): ID/EX <- bubble; later stages advance; lw's own bundle moves on,
//    so hazard_o lasts exactly one cycle per load-use pair.
//  Bubble = all-zero bundle, rd=0; never writes, never hazards.
//  Reset mid-operation discards all in-flight bundles; first post-reset ex_* reflects ID of
//   cycle after rst_i deasserts.
// TESTING
//  1 rst_i=1 for 2 cycles with Op_i=0000011 -> all outputs 0 during and 1 cycle after release.
//  2 sequence addi,add,lw,sw,beq (rd/rs disjoint) -> ex_ALUOp 11,10,00,00,01 on cycles 1..5;
//    wb_RegWrite 1,1,1,0,0 on cycles 3..7; wb_Mem2Reg only for lw; no hazard_o.
//  3 lw x5 then add x6,x5,x1 -> hazard_o=1 one cycle; ex_* all 0 next cycle; add's bundle on
//    ex_* the cycle after; lw rd=x0 followed by use of x0 -> hazard_o never asserts.
//  4 Op_i=1111111 valid -> illegal_o=1 next cycle, all ex/mem/wb control 0 along the pipe;
//    EXT_EN=0 build with jal -> illegal_o=1.
//  5 lw in ID/EX + dependent add, stall_i=1 for 3 cycles -> outputs frozen, hazard_o held 1;
//    after release hazard bubble inserted once.
//  6 flush_i and hazard_o same cycle -> single bubble in ID/EX; flush with stall_i=1 -> no change.

Source files
------------

// File: rtl/ctrl_pipe_unit.sv
// Pipelined RV32 main decoder: decodes the ID opcode and carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, with load-use bubble insertion, flush and stall.
module ctrl_pipe_unit #(
  parameter int OPW    = 7,
  parameter int RIW    = 5,
  parameter bit EXT_EN = 1'b1,
  parameter bit HAZ_EN = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  input  logic [OPW-1:0] Op_i,
  input  logic [2:0]     funct3_i,
  input  logic [RIW-1:0] rs1_i,
  input  logic [RIW-1:0] rs2_i,
  input  logic [RIW-1:0] rd_i,
  input  logic           stall_i,
  input  logic           flush_i,
  output logic           hazard_o,
  output logic           illegal_o,
  output logic [1:0]     ex_ALUOp_o,
  output logic           ex_ALUSrc_o,
  output logic           ex_Branch_o,
  output logic           ex_BrNe_o,
  output logic           ex_Jump_o,
  output logic           mem_MemRead_o,
  output logic           mem_MemWrite_o,
  output logic           wb_RegWrite_o,
  output logic           wb_Mem2Reg_o
);

  localparam logic [OPW-1:0] OP_IALU   = OPW'(7'b0010011);
  localparam logic [OPW-1:0] OP_RTYPE  = OPW'(7'b0110011);
  localparam logic [OPW-1:0] OP_BRANCH = OPW'(7'b1100011);
  localparam logic [OPW-1:0] OP_LOAD   = OPW'(7'b0000011);
  localparam logic [OPW-1:0] OP_STORE  = OPW'(7'b0100011);
  localparam logic [OPW-1:0] OP_JAL    = OPW'(7'b1101111);
  localparam logic [OPW-1:0] OP_LUI    = OPW'(7'b0110111);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       br_ne;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem2reg;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t          ctrl;
    logic [RIW-1:0] rd;
  } idex_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem2reg;
  } exmem_t;

  typedef struct packed {
    logic reg_write;
    logic mem2reg;
  } memwb_t;

  ctrl_t          dec;
  logic [RIW-1:0] id_rd;
  idex_t          idex;
  exmem_t         exmem;
  memwb_t         memwb;
  logic           hazard;

  // ID-stage decode; a non-valid slot decodes as a bubble and is never flagged illegal.
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a latch behind.
    dec = '0;
    if (valid_i) begin
      case (Op_i)
        OP_IALU: begin
          dec.alu_op    = ALU_I;
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
        end
        OP_RTYPE: begin
          dec.alu_op    = ALU_R;
          dec.reg_write = 1'b1;
        end
        OP_BRANCH: begin
          if (funct3_i == 3'b000) begin
            dec.alu_op = ALU_BR;
            dec.branch = 1'b1;
          end else if (EXT_EN && funct3_i == 3'b001) begin
            dec.alu_op = ALU_BR;
            dec.branch = 1'b1;
            dec.br_ne  = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_LOAD: begin
          dec.alu_op    = ALU_ADD;
          dec.alu_src   = 1'b1;
          dec.mem_read  = 1'b1;
          dec.reg_write = 1'b1;
          dec.mem2reg   = 1'b1;
        end
        OP_STORE: begin
          dec.alu_op    = ALU_ADD;
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
        end
        OP_JAL: begin
          if (EXT_EN) begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        OP_LUI: begin
          if (EXT_EN) begin
            dec.alu_src   = 1'b1;
            dec.reg_write = 1'b1;
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  assign id_rd = valid_i ? rd_i : '0;

  // Load-use check against the held ID/EX entry; rs2 is compared for every opcode on purpose.
  assign hazard = HAZ_EN && !rst_i && valid_i && idex.ctrl.mem_read && (idex.rd != '0) &&
                  ((idex.rd == rs1_i) || (idex.rd == rs2_i));

  always_ff @(posedge clk_i) begin
    // NOTE: stage registers use non-blocking assignments so every stage samples the old value.
    if (rst_i) begin
      idex  <= '0;
      exmem <= '0;
      memwb <= '0;
    end else if (!stall_i) begin
      if (flush_i || hazard) begin
        idex <= '0;
      end else begin
        idex <= '{ctrl: dec, rd: id_rd};
      end
      exmem <= '{mem_read:  idex.ctrl.mem_read,
                 mem_write: idex.ctrl.mem_write,
                 reg_write: idex.ctrl.reg_write,
                 mem2reg:   idex.ctrl.mem2reg};
      memwb <= '{reg_write: exmem.reg_write,
                 mem2reg:   exmem.mem2reg};
    end
  end

  assign hazard_o       = hazard;
  assign illegal_o      = idex.ctrl.illegal;
  assign ex_ALUOp_o     = idex.ctrl.alu_op;
  assign ex_ALUSrc_o    = idex.ctrl.alu_src;
  assign ex_Branch_o    = idex.ctrl.branch;
  assign ex_BrNe_o      = idex.ctrl.br_ne;
  assign ex_Jump_o      = idex.ctrl.jump;
  assign mem_MemRead_o  = exmem.mem_read;
  assign mem_MemWrite_o = exmem.mem_write;
  assign wb_RegWrite_o  = memwb.reg_write;
  assign wb_Mem2Reg_o   = memwb.mem2reg;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Directed self-checking bench for ctrl_pipe_unit: reset, decode sequence, load-use,
// illegal opcodes, stall and flush interaction, with a second instance built without EXT_EN.
module tb_ctrl_pipe_unit;

  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BAD  = 7'b1111111;

  // ex vector = {ALUOp[1:0], ALUSrc, Branch, BrNe, Jump}
  localparam logic [5:0] EX_ADDI = 6'b11_1_0_0_0;
  localparam logic [5:0] EX_ADD  = 6'b10_0_0_0_0;
  localparam logic [5:0] EX_LDST = 6'b00_1_0_0_0;
  localparam logic [5:0] EX_BEQ  = 6'b01_0_1_0_0;
  localparam logic [5:0] EX_BNE  = 6'b01_0_1_1_0;
  localparam logic [5:0] EX_JAL  = 6'b00_0_0_0_1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] f3 = '0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       stall = 1'b0, flush = 1'b0;

  logic       hazard, illegal, ex_src, ex_br, ex_brne, ex_jump, mem_rd, mem_wr, wb_rw, wb_m2r;
  logic [1:0] ex_aluop;
  logic       n_hazard, n_illegal, n_ex_src, n_ex_br, n_ex_brne, n_ex_jump;
  logic       n_mem_rd, n_mem_wr, n_wb_rw, n_wb_m2r;
  logic [1:0] n_ex_aluop;

  logic [5:0] ex_v;
  logic [1:0] mem_v, wb_v;
  assign ex_v  = {ex_aluop, ex_src, ex_br, ex_brne, ex_jump};
  assign mem_v = {mem_rd, mem_wr};
  assign wb_v  = {wb_rw, wb_m2r};

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ctrl_pipe_unit #(.OPW(7), .RIW(5), .EXT_EN(1'b1), .HAZ_EN(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .funct3_i(f3),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .stall_i(stall), .flush_i(flush),
    .hazard_o(hazard), .illegal_o(illegal), .ex_ALUOp_o(ex_aluop), .ex_ALUSrc_o(ex_src),
    .ex_Branch_o(ex_br), .ex_BrNe_o(ex_brne), .ex_Jump_o(ex_jump),
    .mem_MemRead_o(mem_rd), .mem_MemWrite_o(mem_wr),
    .wb_RegWrite_o(wb_rw), .wb_Mem2Reg_o(wb_m2r)
  );

  ctrl_pipe_unit #(.OPW(7), .RIW(5), .EXT_EN(1'b0), .HAZ_EN(1'b1)) u_noext (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .Op_i(op), .funct3_i(f3),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .stall_i(stall), .flush_i(flush),
    .hazard_o(n_hazard), .illegal_o(n_illegal), .ex_ALUOp_o(n_ex_aluop), .ex_ALUSrc_o(n_ex_src),
    .ex_Branch_o(n_ex_br), .ex_BrNe_o(n_ex_brne), .ex_Jump_o(n_ex_jump),
    .mem_MemRead_o(n_mem_rd), .mem_MemWrite_o(n_mem_wr),
    .wb_RegWrite_o(n_wb_rw), .wb_Mem2Reg_o(n_wb_m2r)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives the ID slot and waits for combinational outputs to settle.
  task automatic set_id(input logic v, input logic [6:0] o, input logic [2:0] fn,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
    valid = v; op = o; f3 = fn; rs1 = s1; rs2 = s2; rd = d;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ex"}, {2'b0, ex_v}, 8'h00);
    check({tag, "_mem"}, {6'b0, mem_v}, 8'h00);
    check({tag, "_wb"}, {6'b0, wb_v}, 8'h00);
    check({tag, "_ill"}, {7'b0, illegal}, 8'h00);
    check({tag, "_hz"}, {7'b0, hazard}, 8'h00);
  endtask

  logic [6:0] seq_op  [5] = '{OP_ADDI, OP_ADD, OP_LW, OP_SW, OP_BR};
  logic [4:0] seq_rd  [5] = '{5'd1, 5'd4, 5'd7, 5'd0, 5'd0};
  logic [5:0] seq_ex  [5] = '{EX_ADDI, EX_ADD, EX_LDST, EX_LDST, EX_BEQ};
  logic [1:0] seq_mem [5] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
  logic [1:0] seq_wb  [5] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b00};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held two cycles with a load sitting in ID.
    rst = 1'b1;
    set_id(1'b1, OP_LW, 3'd0, 5'd0, 5'd0, 5'd5);
    tick();
    check_zero("rst_c1");
    tick();
    check_zero("rst_c2");
    rst = 1'b0;
    #1;
    check_zero("rst_rel");
    tick();
    check("rst_first_ex", {2'b0, ex_v}, {2'b0, EX_LDST});
    idle(4);

    // Independent sequence addi, add, lw, sw, beq.
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_id(1'b1, seq_op[i], 3'b000, 5'd2, 5'd3, seq_rd[i]);
      else       set_id(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
      check($sformatf("seq_hz%0d", i), {7'b0, hazard}, 8'h00);
      tick();
      if (i < 5) check($sformatf("seq_ex%0d", i), {2'b0, ex_v}, {2'b0, seq_ex[i]});
      if (i >= 1 && i <= 5) check($sformatf("seq_mem%0d", i), {6'b0, mem_v}, {6'b0, seq_mem[i-1]});
      if (i >= 2) check($sformatf("seq_wb%0d", i), {6'b0, wb_v}, {6'b0, seq_wb[i-2]});
    end
    idle(3);

    // Load-use: lw x5 then add x6,x5,x1.
    set_id(1'b1, OP_LW, 3'd0, 5'd1, 5'd2, 5'd5);
    check("lu_hz_pre", {7'b0, hazard}, 8'h00);
    tick();
    set_id(1'b1, OP_ADD, 3'd0, 5'd5, 5'd1, 5'd6);
    check("lu_hz_on", {7'b0, hazard}, 8'h01);
    tick();
    check("lu_bubble_ex", {2'b0, ex_v}, 8'h00);
    check("lu_bubble_mem", {6'b0, mem_v}, 8'h02);
    check("lu_hz_off", {7'b0, hazard}, 8'h00);
    tick();
    check("lu_add_ex", {2'b0, ex_v}, {2'b0, EX_ADD});
    check("lu_lw_wb", {6'b0, wb_v}, 8'h03);
    idle(3);

    // lw with rd=x0 never hazards.
    set_id(1'b1, OP_LW, 3'd0, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OP_ADD, 3'd0, 5'd0, 5'd0, 5'd6);
    check("x0_hz", {7'b0, hazard}, 8'h00);
    tick();
    check("x0_add_ex", {2'b0, ex_v}, {2'b0, EX_ADD});
    idle(3);

    // Illegal opcode travels as an all-zero bundle.
    set_id(1'b1, OP_BAD, 3'd0, 5'd1, 5'd2, 5'd3);
    tick();
    check("ill_flag", {7'b0, illegal}, 8'h01);
    check("ill_ex", {2'b0, ex_v}, 8'h00);
    set_id(1'b1, OP_BR, 3'b010, 5'd1, 5'd2, 5'd0);
    tick();
    check("ill_mem", {6'b0, mem_v}, 8'h00);
    check("ill_br_f3", {7'b0, illegal}, 8'h01);
    set_id(1'b1, OP_JAL, 3'd0, 5'd0, 5'd0, 5'd1);
    tick();
    check("ill_wb", {6'b0, wb_v}, 8'h00);
    check("jal_ex", {2'b0, ex_v}, {2'b0, EX_JAL});
    check("jal_legal", {7'b0, illegal}, 8'h00);
    check("noext_jal_ill", {7'b0, n_illegal}, 8'h01);
    check("noext_jal_ex", {2'b0, n_ex_aluop, n_ex_src, n_ex_br, n_ex_brne, n_ex_jump}, 8'h00);
    set_id(1'b1, OP_BR, 3'b001, 5'd1, 5'd2, 5'd0);
    tick();
    check("bne_ex", {2'b0, ex_v}, {2'b0, EX_BNE});
    check("noext_bne_ill", {7'b0, n_illegal}, 8'h01);
    check("jal_mem_wb", {4'b0, mem_v, wb_v}, 8'h00);
    set_id(1'b1, OP_LUI, 3'd0, 5'd0, 5'd0, 5'd9);
    tick();
    check("lui_ex", {2'b0, ex_v}, {2'b0, EX_LDST});
    check("lui_legal", {7'b0, illegal}, 8'h00);
    check("jal_wb", {6'b0, wb_v}, 8'h02);
    idle(4);

    // External stall with a pending load-use pair.
    set_id(1'b1, OP_LW, 3'd0, 5'd1, 5'd2, 5'd5);
    tick();
    stall = 1'b1;
    set_id(1'b1, OP_ADD, 3'd0, 5'd5, 5'd1, 5'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall_ex%0d", i), {2'b0, ex_v}, {2'b0, EX_LDST});
      check($sformatf("stall_mem%0d", i), {6'b0, mem_v}, 8'h00);
      check($sformatf("stall_hz%0d", i), {7'b0, hazard}, 8'h01);
    end
    stall = 1'b0;
    #1;
    tick();
    check("stall_bubble_ex", {2'b0, ex_v}, 8'h00);
    check("stall_bubble_mem", {6'b0, mem_v}, 8'h02);
    check("stall_hz_off", {7'b0, hazard}, 8'h00);
    tick();
    check("stall_add_ex", {2'b0, ex_v}, {2'b0, EX_ADD});
    idle(3);

    // Flush together with a load-use hazard gives a single bubble.
    set_id(1'b1, OP_LW, 3'd0, 5'd1, 5'd2, 5'd5);
    tick();
    flush = 1'b1;
    set_id(1'b1, OP_ADD, 3'd0, 5'd5, 5'd1, 5'd6);
    check("fh_hz", {7'b0, hazard}, 8'h01);
    tick();
    flush = 1'b0;
    #1;
    check("fh_bubble_ex", {2'b0, ex_v}, 8'h00);
    check("fh_hz_off", {7'b0, hazard}, 8'h00);
    tick();
    check("fh_add_ex", {2'b0, ex_v}, {2'b0, EX_ADD});

    // Plain flush replaces the ID instruction with a bubble.
    flush = 1'b1;
    set_id(1'b1, OP_ADDI, 3'd0, 5'd2, 5'd3, 5'd1);
    tick();
    check("flush_ex", {2'b0, ex_v}, 8'h00);
    flush = 1'b0;
    idle(3);

    // Flush while stalled changes nothing.
    set_id(1'b1, OP_ADDI, 3'd0, 5'd2, 5'd3, 5'd1);
    tick();
    check("sf_pre_ex", {2'b0, ex_v}, {2'b0, EX_ADDI});
    stall = 1'b1;
    flush = 1'b1;
    set_id(1'b1, OP_ADD, 3'd0, 5'd2, 5'd3, 5'd4);
    tick();
    check("sf_hold_ex", {2'b0, ex_v}, {2'b0, EX_ADDI});
    check("sf_hold_mem", {6'b0, mem_v}, 8'h00);
    stall = 1'b0;
    flush = 1'b0;
    #1;
    tick();
    check("sf_add_ex", {2'b0, ex_v}, {2'b0, EX_ADD});
    check("sf_addi_mem", {6'b0, mem_v}, 8'h00);

    // Reset mid-operation discards in-flight bundles.
    set_id(1'b1, OP_LW, 3'd0, 5'd1, 5'd2, 5'd5);
    tick();
    rst = 1'b1;
    set_id(1'b1, OP_ADD, 3'd0, 5'd5, 5'd1, 5'd6);
    check("mid_rst_hz", {7'b0, hazard}, 8'h00);
    tick();
    check_zero("mid_rst");
    rst = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
